// File: rtl/id_pkg.sv
// Shared ID-stage definitions: opcodes, ALU func codes, writeback select and ID/EX control bundle.
package id_pkg;

  localparam logic [3:0] OpLw  = 4'b1000;
  localparam logic [3:0] OpSw  = 4'b1001;
  localparam logic [3:0] OpJal = 4'b1101;
  localparam logic [3:0] OpJr  = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  // ALU ops carry their func in opcode[2:0]; opcode[3] selects the immediate operand.
  localparam logic [2:0] FuncAdd = 3'd0;
  localparam logic [2:0] FuncSub = 3'd1;
  localparam logic [2:0] FuncAnd = 3'd2;
  localparam logic [2:0] FuncOr  = 3'd3;
  localparam logic [2:0] FuncXor = 3'd4;
  localparam logic [2:0] FuncSll = 3'd5;
  localparam logic [2:0] FuncSrl = 3'd6;
  localparam logic [2:0] FuncSra = 3'd7;

  localparam logic WbAlu = 1'b0;
  localparam logic WbMem = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [7:0] imm8;
    logic [3:0] shamt;
    logic [2:0] func;
    logic       src1sel;
    logic       we_rf;
    logic       we_mem;
    logic       re_mem;
    logic       wb_sel;
    logic       hlt;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file: two asynchronous read ports, two synchronous write ports (port 1 wins on a tie).
module id_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra0,
  input  logic [RA_W-1:0]   ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              we0,
  input  logic [RA_W-1:0]   wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [RA_W-1:0]   wa1,
  input  logic [DATA_W-1:0] wd1
);

  logic [DATA_W-1:0] regs [NREG];

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wa0] <= wd0;
      if (we1) regs[wa1] <= wd1;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register, load-use interlock, JAL/JR redirect and sticky halt.
// Optional macro ID_WB_BYPASS_EN forwards the writeback port into same-cycle register reads.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned NREG     = 16,
  parameter int unsigned LINK_REG = NREG - 1,
  localparam int unsigned RA_W    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic [PC_W-1:0]   pc,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              j_ctrl,
  output logic [PC_W-1:0]   j_pc,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_p0,
  output logic [DATA_W-1:0] ex_p1,
  output logic [7:0]        ex_imm8,
  output logic [3:0]        ex_shamt,
  output logic [2:0]        ex_func,
  output logic              ex_src1sel,
  output logic              ex_we_rf,
  output logic              ex_we_mem,
  output logic              ex_re_mem,
  output logic              ex_wb_sel,
  output logic [RA_W-1:0]   ex_dst_addr,
  output logic              ex_hlt,
  output logic              halted
);

  localparam logic [RA_W-1:0] LinkAddr = RA_W'(LINK_REG);

  logic [3:0]        opcode;
  logic              is_jal, is_jr, is_lw, is_sw, is_hlt, is_alu;
  logic [RA_W-1:0]   rs0, rs1, rd;
  logic              en0, en1;
  logic [DATA_W-1:0] rf_p0, rf_p1, p0, p1;
  logic              wb_hazard, load_use, active, issue, link_we;
  logic [PC_W-1:0]   pc_plus1, jal_target;
  id_ex_ctrl_t       ctrl_d, ctrl_q;
  logic [DATA_W-1:0] p0_q, p1_q;
  logic [RA_W-1:0]   dst_q;
  logic              halted_q, halted_d;

  // Field layout: [11:8] rd (SW data source), [7:4] first source, [3:0] second source.
  always_comb begin
    opcode = instr[15:12];
    is_jal = (opcode == OpJal);
    is_jr  = (opcode == OpJr);
    is_lw  = (opcode == OpLw);
    is_sw  = (opcode == OpSw);
    is_hlt = (opcode == OpHlt);
    is_alu = !(is_jal || is_jr || is_lw || is_sw || is_hlt);
    rd     = instr[8 +: RA_W];
    rs0    = instr[4 +: RA_W];
    rs1    = is_sw ? instr[8 +: RA_W] : instr[0 +: RA_W];
    en0    = is_alu || is_lw || is_sw || is_jr;
    en1    = (is_alu && !opcode[3]) || is_sw;
  end

  id_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra0 (rs0),
    .ra1 (rs1),
    .rd0 (rf_p0),
    .rd1 (rf_p1),
    .we0 (wb_we),
    .wa0 (wb_addr),
    .wd0 (wb_data),
    .we1 (link_we),
    .wa1 (LinkAddr),
    .wd1 (DATA_W'(pc_plus1))
  );

`ifdef ID_WB_BYPASS_EN
  assign p0        = (wb_we && (wb_addr == rs0)) ? wb_data : rf_p0;
  assign p1        = (wb_we && (wb_addr == rs1)) ? wb_data : rf_p1;
  assign wb_hazard = 1'b0;
`else
  assign p0        = rf_p0;
  assign p1        = rf_p1;
  assign wb_hazard = wb_we && ((en0 && (rs0 == wb_addr)) || (en1 && (rs1 == wb_addr)));
`endif

  assign pc_plus1   = pc + PC_W'(1);
  assign jal_target = pc_plus1 + {{(PC_W-12){instr[11]}}, instr[11:0]};

  always_comb begin
    load_use = ctrl_q.valid && ctrl_q.re_mem &&
               ((en0 && (rs0 == dst_q)) || (en1 && (rs1 == dst_q)));
    active   = if_valid && !flush && !halted_q;
    id_stall = active && (load_use || wb_hazard);
    j_ctrl   = active && (is_jal || (is_jr && !id_stall));
    j_pc     = is_jal ? jal_target : p0[PC_W-1:0];
    link_we  = active && is_jal;
    issue    = active && !id_stall && !is_jal && !is_jr;
    halted_d = halted_q || (issue && is_hlt);

    ctrl_d = '0;
    if (issue) begin
      ctrl_d.valid   = 1'b1;
      ctrl_d.imm8    = instr[7:0];
      ctrl_d.shamt   = instr[3:0];
      ctrl_d.func    = is_alu ? opcode[2:0] : FuncAdd;
      ctrl_d.src1sel = is_alu ? opcode[3] : (is_lw || is_sw);
      ctrl_d.we_rf   = is_alu || is_lw;
      ctrl_d.we_mem  = is_sw;
      ctrl_d.re_mem  = is_lw;
      ctrl_d.wb_sel  = is_lw ? WbMem : WbAlu;
      ctrl_d.hlt     = is_hlt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      dst_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      p0_q     <= p0;
      p1_q     <= p1;
      dst_q    <= rd;
      halted_q <= halted_d;
    end
  end

  assign ex_valid    = ctrl_q.valid;
  assign ex_p0       = p0_q;
  assign ex_p1       = p1_q;
  assign ex_imm8     = ctrl_q.imm8;
  assign ex_shamt    = ctrl_q.shamt;
  assign ex_func     = ctrl_q.func;
  assign ex_src1sel  = ctrl_q.src1sel;
  assign ex_we_rf    = ctrl_q.we_rf;
  assign ex_we_mem   = ctrl_q.we_mem;
  assign ex_re_mem   = ctrl_q.re_mem;
  assign ex_wb_sel   = ctrl_q.wb_sel;
  assign ex_dst_addr = dst_q;
  assign ex_hlt      = ctrl_q.hlt;
  assign halted      = halted_q;

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/datapath width.
REQ-002 SHALL have parameter PC_W, default 16, program-counter width.
REQ-003 SHALL have parameter NREG, default 16, register count (power of 2); RA_W = log2(NREG).
REQ-004 SHALL have parameter LINK_REG, default NREG-1, JAL link register index.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr  in  16  instruction from fetch
- pc  in  PC_W  PC of instr
- if_valid  in  1  instr valid
- flush  in  1  EX branch taken; kill ID instruction
- wb_we / wb_addr / wb_data  in  1 / RA_W / DATA_W  writeback port
- id_stall  out  1  hold fetch (combinational)
- j_ctrl / j_pc  out  1 / PC_W  jump redirect (combinational)
- ex_valid, ex_p0, ex_p1, ex_imm8[7:0], ex_shamt[3:0], ex_func[2:0], ex_src1sel, ex_we_rf, ex_we_mem, ex_re_mem, ex_wb_sel, ex_dst_addr[RA_W-1:0], ex_hlt  out  registered ID/EX pipeline outputs
- halted  out  1  sticky halt

Function
REQ-007 SHALL decode instr[15:12] as opcode; JAL=4'b1101, JR=4'b1110, LW=4'b1000, SW=4'b1001, HLT=4'b1111; all others ALU.
REQ-008 SHALL capture all ex_* fields on every rising clk edge unless a bubble is inserted; latency instr→ex_* is 1 cycle.
REQ-009 Bubble: ex_valid=0, ex_we_rf=0, ex_we_mem=0, ex_re_mem=0, ex_hlt=0; other ex_* don't-care.
REQ-010 Load-use: id_stall=1 when if_valid, ex_valid, ex_re_mem, and an enabled source address equals ex_dst_addr; a bubble is inserted and fetch SHALL hold instr/pc.
REQ-011 flush=1 SHALL force a bubble, force id_stall=0 and j_ctrl=0, and suppress the JAL link write; flush beats stall.
REQ-012 JAL: j_ctrl=1 same cycle; j_pc = pc + 1 + signext(instr[11:0]) mod 2^PC_W; pc+1 (zero-extended/truncated to DATA_W) written to LINK_REG at the edge.
REQ-013 JR: j_ctrl=1, j_pc = p0[PC_W-1:0] (bypassed value); during a JR load-use stall j_ctrl=0.
REQ-014 JAL and JR SHALL enter EX as bubbles except the JAL link write.
REQ-015 Simultaneous JAL link and wb_we to LINK_REG: link write wins; to other addresses both commit.
REQ-016 HLT SHALL issue once with ex_hlt=1, set halted; while halted every cycle is a bubble, j_ctrl=0, id_stall=0, until rst.
REQ-017 if_valid=0 SHALL produce a bubble and no stall/jump.

Reset
REQ-018 rst SHALL clear all registers to 0, all ex_* to 0, halted=0 at the next edge; reset mid-stall or mid-halt returns to idle; rst beats flush, stall and writes.

Configuration
REQ-019 Macro ID_WB_BYPASS_EN defined: a read whose address equals wb_addr with wb_we=1 SHALL return wb_data in the same cycle (also for JR target).
REQ-020 ID_WB_BYPASS_EN undefined: no bypass; id_stall additionally asserts one cycle when an enabled source equals wb_addr with wb_we=1.

Structure
REQ-021 Package id_pkg SHALL hold opcode constants, func encodings, wb_sel encoding and the ID/EX field struct.
REQ-022 Register file SHALL be sub-module id_regfile: 2 async read ports, 2 sync write ports (wb and link, link priority), synchronous reset.

Verification
REQ-023 LW r3 in EX, ADD r4,r3,r1 in ID → id_stall=1 one cycle, ex_valid=0, then ADD issues with ex_p0 = loaded r3.
REQ-024 JAL at pc=16'h0010, offset 12'hFF0 → j_ctrl=1, j_pc=16'h0001; next cycle R15=16'h0011, ex_valid=0.
REQ-025 JR r2 (r2=16'h0040) with wb_we writing r2=16'h0080 same cycle → bypass on: j_pc=16'h0080; off: id_stall=1 then j_pc=16'h0080.
REQ-026 JAL with flush=1 → j_ctrl=0, R15 unchanged, ex_valid=0.
REQ-027 HLT then ALU stream → ex_hlt=1 once, halted=1, all later ex_valid=0; rst → halted=0, registers read 0.
